// File: rtl/div_param.sv
// Parametrised shift-subtract divider: 2W/W -> W quotient and remainder,
// signed or unsigned, one quotient bit per clock, with overflow and div-by-zero flags.
module div_param #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic           signed_op,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           overflow,
    output logic           div_zero
);

    localparam int CW = $clog2(2 * W + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_HOLD} state_t;

    state_t         state_q, state_d;
    logic [2*W-1:0] q_q, q_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   dv_q, dv_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           sgn_q, sgn_d;
    logic           rneg_q, rneg_d;
    logic           dneg_q, dneg_d;
    logic           zero_q, zero_d;
    logic [W-1:0]   quo_q, quo_d;
    logic [W-1:0]   rem_q, rem_d;
    logic           ov_q, ov_d;
    logic           dz_q, dz_d;

    logic [2*W-1:0] dd_abs;
    logic [W-1:0]   dv_abs;
    logic [W:0]     sh, diff;
    logic           ge;
    logic [W-1:0]   a_nxt;
    logic [2*W-1:0] q_nxt;
    logic [W-1:0]   q_lo, q_res, r_res;
    logic           hi_nz, ov_res;

    assign dd_abs = (signed_op && dividend[2*W-1]) ? -dividend : dividend;
    assign dv_abs = (signed_op && divisor[W-1]) ? -divisor : divisor;

    // q_q starts as the dividend magnitude and fills with quotient bits
    assign sh    = {a_q, q_q[2*W-1]};
    assign diff  = sh - {1'b0, dv_q};
    assign ge    = (sh >= {1'b0, dv_q});
    assign a_nxt = ge ? diff[W-1:0] : sh[W-1:0];
    assign q_nxt = {q_q[2*W-2:0], ge};

    assign q_lo  = q_nxt[W-1:0];
    assign q_res = rneg_q ? -q_lo : q_lo;
    assign r_res = dneg_q ? -a_nxt : a_nxt;
    assign hi_nz = |q_nxt[2*W-1:W];

    always_comb begin
        ov_res = hi_nz;
        if (sgn_q) begin
            if (rneg_q)
                ov_res = hi_nz | (q_nxt[W-1] & (|q_nxt[W-2:0]));
            else
                ov_res = hi_nz | q_nxt[W-1];
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        a_d     = a_q;
        dv_d    = dv_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        rneg_d  = rneg_q;
        dneg_d  = dneg_q;
        zero_d  = zero_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        ov_d    = ov_q;
        dz_d    = dz_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    ov_d    = 1'b0;
                    dz_d    = 1'b0;
                    a_d     = '0;
                    sgn_d   = signed_op;
                    dneg_d  = signed_op & dividend[2*W-1];
                    rneg_d  = signed_op & (dividend[2*W-1] ^ divisor[W-1]);
                    dv_d    = dv_abs;
                    state_d = S_RUN;
                    // a zero divisor takes a single flag-only cycle in RUN
                    if (divisor == '0) begin
                        zero_d = 1'b1;
                        q_d    = dividend;
                        cnt_d  = CW'(1);
                    end else begin
                        zero_d = 1'b0;
                        q_d    = dd_abs;
                        cnt_d  = CW'(2 * W);
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (zero_q) begin
                    quo_d   = '0;
                    rem_d   = q_q[W-1:0];
                    ov_d    = 1'b1;
                    dz_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    a_d = a_nxt;
                    q_d = q_nxt;
                    if (cnt_q == CW'(1)) begin
                        quo_d   = q_res;
                        rem_d   = r_res;
                        ov_d    = ov_res;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: state_d = start ? S_HOLD : S_IDLE;
            S_HOLD: if (!start) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            a_q     <= '0;
            dv_q    <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dneg_q  <= 1'b0;
            zero_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            ov_q    <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            a_q     <= a_d;
            dv_q    <= dv_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            rneg_q  <= rneg_d;
            dneg_q  <= dneg_d;
            zero_q  <= zero_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            ov_q    <= ov_d;
            dz_q    <= dz_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign overflow  = ov_q;
    assign div_zero  = dz_q;

endmodule
